counter_sequencer: RTL and testbench

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

---
 rtl/counter_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_counter_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : counter_sequencer
// Purpose  : Command-driven up/down counter with a prescaler, a terminal
//            limit, and one-shot or auto-reload operation, sequenced by a
//            four-state FSM (IDLE / RUN / PAUSE / DONE).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      synchronous active-low reset
//   ena        in   1      global enable; low freezes all state
//   cmd_valid  in   1      command present
//   cmd_ready  out  1      command acceptable (mirrors ena, combinational)
//   cmd_op     in   3      0 NOP, 1 LOAD, 2 SET_LIMIT, 3 SET_PRESCALE,
//                          4 START_UP, 5 START_DOWN, 6 PAUSE, 7 STOP
//   cmd_data   in   WIDTH  operand; START ops use bit0 as auto-reload flag
//   count      out  WIDTH  current counter value (registered)
//   state_o    out  2      IDLE=0, RUN=1, PAUSE=2, DONE=3
//   running    out  1      high while in RUN
//   done       out  1      one-cycle terminal-count pulse (registered)
//   cmd_err    out  1      one-cycle pulse for a command illegal in its state
// ============================================================================
module counter_sequencer #(
  parameter int WIDTH = 8,
  parameter int PW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state_o,
  output logic             running,
  output logic             done,
  output logic             cmd_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] c_OP_LOAD       = 3'd1;
  localparam logic [2:0] c_OP_SET_LIMIT  = 3'd2;
  localparam logic [2:0] c_OP_SET_PRESC  = 3'd3;
  localparam logic [2:0] c_OP_START_UP   = 3'd4;
  localparam logic [2:0] c_OP_START_DOWN = 3'd5;
  localparam logic [2:0] c_OP_PAUSE      = 3'd6;
  localparam logic [2:0] c_OP_STOP       = 3'd7;

  localparam logic [WIDTH-1:0] c_CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    c_PRESC_ONE = {{(PW-1){1'b0}}, 1'b1};

  // Registered state
  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] r_limit;
  logic [PW-1:0]    r_prescale;
  logic [PW-1:0]    r_presc;
  logic             r_down;
  logic             r_auto;
  logic             r_done;
  logic             r_err;

  // Next-state values
  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_reload_nxt;
  logic [WIDTH-1:0] w_limit_nxt;
  logic [PW-1:0]    w_prescale_nxt;
  logic [PW-1:0]    w_presc_nxt;
  logic             w_down_nxt;
  logic             w_auto_nxt;
  logic             w_done_nxt;
  logic             w_err_nxt;

  logic             w_accept;
  logic             w_tick;
  logic             w_cfg_ok;

  assign cmd_ready = ena;
  assign w_accept  = cmd_valid && ena;
  assign w_tick    = (r_state == S_RUN) && (r_presc == r_prescale);
  // Config ops and START are only meaningful while the counter is not running.
  assign w_cfg_ok  = (r_state != S_RUN);

  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_reload_nxt   = r_reload;
    w_limit_nxt    = r_limit;
    w_prescale_nxt = r_prescale;
    w_presc_nxt    = r_presc;
    w_down_nxt     = r_down;
    w_auto_nxt     = r_auto;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;

    if (ena) begin
      // Free-running counting behaviour; an accepted PAUSE/STOP below
      // overrides whatever the tick decided on the same edge.
      if (r_state == S_RUN) begin
        if (w_tick) begin
          w_presc_nxt = '0;
          if (r_count == r_limit) begin
            w_done_nxt = 1'b1;
            if (r_auto) begin
              w_count_nxt = r_reload;
            end else begin
              w_state_nxt = S_DONE;
            end
          end else if (r_down) begin
            w_count_nxt = r_count - c_CNT_ONE;
          end else begin
            w_count_nxt = r_count + c_CNT_ONE;
          end
        end else begin
          w_presc_nxt = r_presc + c_PRESC_ONE;
        end
      end

      if (w_accept) begin
        case (cmd_op)
          c_OP_LOAD: begin
            if (w_cfg_ok) begin
              w_reload_nxt = cmd_data;
              w_count_nxt  = cmd_data;
            end else begin
              w_err_nxt = 1'b1;
            end
          end
          c_OP_SET_LIMIT: begin
            if (w_cfg_ok) w_limit_nxt = cmd_data;
            else          w_err_nxt   = 1'b1;
          end
          c_OP_SET_PRESC: begin
            if (w_cfg_ok) w_prescale_nxt = cmd_data[PW-1:0];
            else          w_err_nxt      = 1'b1;
          end
          c_OP_START_UP, c_OP_START_DOWN: begin
            if (r_state == S_RUN) begin
              w_err_nxt = 1'b1;
            end else begin
              // Resuming from PAUSE keeps count and prescaler phase.
              if (r_state != S_PAUSE) begin
                w_count_nxt = r_reload;
                w_presc_nxt = '0;
              end
              w_down_nxt  = (cmd_op == c_OP_START_DOWN);
              w_auto_nxt  = cmd_data[0];
              w_state_nxt = S_RUN;
            end
          end
          c_OP_PAUSE: begin
            if (r_state == S_RUN) begin
              w_state_nxt = S_PAUSE;
              w_count_nxt = r_count;
              w_presc_nxt = r_presc;
              w_done_nxt  = 1'b0;
            end else begin
              w_err_nxt = 1'b1;
            end
          end
          c_OP_STOP: begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
            w_presc_nxt = '0;
            w_done_nxt  = 1'b0;
          end
          default: begin
            // NOP
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_reload   <= '0;
      r_limit    <= '1;
      r_prescale <= '0;
      r_presc    <= '0;
      r_down     <= 1'b0;
      r_auto     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_reload   <= w_reload_nxt;
      r_limit    <= w_limit_nxt;
      r_prescale <= w_prescale_nxt;
      r_presc    <= w_presc_nxt;
      r_down     <= w_down_nxt;
      r_auto     <= w_auto_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign count   = r_count;
  assign state_o = r_state;
  assign running = (r_state == S_RUN);
  assign done    = r_done;
  assign cmd_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_sequencer
// Purpose  : Directed self-checking bench for counter_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_sequencer;

  localparam int WIDTH = 8;
  localparam int PW    = 4;

  localparam logic [2:0] c_NOP = 3'd0, c_LOAD = 3'd1, c_LIM = 3'd2, c_PSC = 3'd3;
  localparam logic [2:0] c_UP  = 3'd4, c_DOWN = 3'd5, c_PAUSE = 3'd6, c_STOP = 3'd7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ena;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] count;
  logic [1:0]       state_o;
  logic             running;
  logic             done;
  logic             cmd_err;

  int n_checks = 0;
  int n_fail   = 0;

  counter_sequencer #(.WIDTH(WIDTH), .PW(PW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .count     (count),
    .state_o   (state_o),
    .running   (running),
    .done      (done),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cyc();
    cmd_valid = 1'b0;
    cmd_op    = c_NOP;
    cmd_data  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    if (count !== 8'd0) begin $display("FAIL reset_count: got %0d expected 0", count); n_fail++; end
    n_checks++;
    if (state_o !== 2'd0) begin $display("FAIL reset_state: got %0d expected 0", state_o); n_fail++; end
    n_checks++;
    if (running !== 1'b0 || done !== 1'b0 || cmd_err !== 1'b0) begin
      $display("FAIL reset_flags: running=%b done=%b cmd_err=%b expected 0 0 0", running, done, cmd_err); n_fail++;
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin $display("FAIL reset_ready: got %b expected 1", cmd_ready); n_fail++; end
    n_checks++;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_oneshot_up();
    logic [7:0] e;
    send(c_LOAD, 8'd250);
    if (count !== 8'd250) begin $display("FAIL load_count: got %0d expected 250", count); n_fail++; end
    n_checks++;
    send(c_LIM, 8'd3);
    send(c_UP, 8'd0);
    if (count !== 8'd250 || state_o !== 2'd1 || running !== 1'b1) begin
      $display("FAIL start_up: count=%0d state=%0d running=%b expected 250 1 1", count, state_o, running); n_fail++;
    end
    n_checks++;
    e = 8'd250;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      e = e + 8'd1;
      if (count !== e || done !== 1'b0 || state_o !== 2'd1) begin
        $display("FAIL oneshot_step%0d: count=%0d done=%b state=%0d expected %0d 0 1", i, count, done, state_o, e); n_fail++;
      end
      n_checks++;
    end
    cyc();
    if (count !== 8'd3 || done !== 1'b1 || state_o !== 2'd3) begin
      $display("FAIL oneshot_term: count=%0d done=%b state=%0d expected 3 1 3", count, done, state_o); n_fail++;
    end
    n_checks++;
    cyc();
    if (count !== 8'd3 || done !== 1'b0 || state_o !== 2'd3) begin
      $display("FAIL oneshot_hold: count=%0d done=%b state=%0d expected 3 0 3", count, done, state_o); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_prescale();
    logic [7:0] exp_c [6];
    exp_c = '{8'd10, 8'd10, 8'd11, 8'd11, 8'd11, 8'd12};
    send(c_PSC, 8'd2);
    send(c_LOAD, 8'd10);
    send(c_LIM, 8'd255);
    send(c_UP, 8'd0);
    if (count !== 8'd10 || running !== 1'b1) begin
      $display("FAIL psc_start: count=%0d running=%b expected 10 1", count, running); n_fail++;
    end
    n_checks++;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (count !== exp_c[i]) begin
        $display("FAIL psc_step%0d: got %0d expected %0d", i + 1, count, exp_c[i]); n_fail++;
      end
      n_checks++;
    end
    send(c_STOP, 8'd0);
    if (count !== 8'd0 || state_o !== 2'd0) begin
      $display("FAIL stop: count=%0d state=%0d expected 0 0", count, state_o); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_autoreload_down();
    logic [7:0] exp_c [8];
    logic       exp_d [8];
    exp_c = '{8'd4, 8'd3, 8'd2, 8'd5, 8'd4, 8'd3, 8'd2, 8'd5};
    exp_d = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    send(c_PSC, 8'd0);
    send(c_LOAD, 8'd5);
    send(c_LIM, 8'd2);
    send(c_DOWN, 8'd1);
    if (count !== 8'd5) begin $display("FAIL ar_start: got %0d expected 5", count); n_fail++; end
    n_checks++;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (count !== exp_c[i] || done !== exp_d[i] || state_o !== 2'd1) begin
        $display("FAIL ar_step%0d: count=%0d done=%b state=%0d expected %0d %b 1",
                 i + 1, count, done, state_o, exp_c[i], exp_d[i]); n_fail++;
      end
      n_checks++;
    end
  endtask

  task automatic test_illegal();
    // Still RUNning down with count 5, limit 2, reload 5.
    send(c_LIM, 8'd7);
    if (cmd_err !== 1'b1 || count !== 8'd4 || state_o !== 2'd1) begin
      $display("FAIL ill_setlimit: cmd_err=%b count=%0d state=%0d expected 1 4 1", cmd_err, count, state_o); n_fail++;
    end
    n_checks++;
    cyc();
    if (cmd_err !== 1'b0 || count !== 8'd3) begin
      $display("FAIL ill_errpulse: cmd_err=%b count=%0d expected 0 3", cmd_err, count); n_fail++;
    end
    n_checks++;
    cyc();
    cyc();
    if (count !== 8'd5 || done !== 1'b1) begin
      $display("FAIL ill_limit_kept: count=%0d done=%b expected 5 1", count, done); n_fail++;
    end
    n_checks++;
    send(c_STOP, 8'd0);
    send(c_PAUSE, 8'd0);
    if (cmd_err !== 1'b1 || state_o !== 2'd0) begin
      $display("FAIL ill_pause_idle: cmd_err=%b state=%0d expected 1 0", cmd_err, state_o); n_fail++;
    end
    n_checks++;
    send(c_NOP, 8'd0);
    if (cmd_err !== 1'b0 || state_o !== 2'd0 || count !== 8'd0) begin
      $display("FAIL nop: cmd_err=%b state=%0d count=%0d expected 0 0 0", cmd_err, state_o, count); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_pause_on_tick();
    send(c_LOAD, 8'd0);
    send(c_LIM, 8'd3);
    send(c_UP, 8'd0);
    cyc();
    cyc();
    if (count !== 8'd2) begin $display("FAIL pt_pre: got %0d expected 2", count); n_fail++; end
    n_checks++;
    send(c_PAUSE, 8'd0);
    if (count !== 8'd2 || state_o !== 2'd2 || done !== 1'b0) begin
      $display("FAIL pt_pause: count=%0d state=%0d done=%b expected 2 2 0", count, state_o, done); n_fail++;
    end
    n_checks++;
    cyc();
    if (count !== 8'd2 || state_o !== 2'd2) begin
      $display("FAIL pt_hold: count=%0d state=%0d expected 2 2", count, state_o); n_fail++;
    end
    n_checks++;
    send(c_UP, 8'd0);
    if (count !== 8'd2 || state_o !== 2'd1) begin
      $display("FAIL pt_resume: count=%0d state=%0d expected 2 1", count, state_o); n_fail++;
    end
    n_checks++;
    cyc();
    if (count !== 8'd3 || done !== 1'b0) begin
      $display("FAIL pt_reach: count=%0d done=%b expected 3 0", count, done); n_fail++;
    end
    n_checks++;
    cyc();
    if (count !== 8'd3 || done !== 1'b1 || state_o !== 2'd3) begin
      $display("FAIL pt_done: count=%0d done=%b state=%0d expected 3 1 3", count, done, state_o); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_stop_on_tick();
    send(c_LOAD, 8'd0);
    send(c_LIM, 8'd1);
    send(c_UP, 8'd0);
    cyc();
    if (count !== 8'd1) begin $display("FAIL st_pre: got %0d expected 1", count); n_fail++; end
    n_checks++;
    send(c_STOP, 8'd0);
    if (count !== 8'd0 || state_o !== 2'd0 || done !== 1'b0) begin
      $display("FAIL st_stop: count=%0d state=%0d done=%b expected 0 0 0", count, state_o, done); n_fail++;
    end
    n_checks++;
    cyc();
    if (done !== 1'b0) begin $display("FAIL st_nodone: got %b expected 0", done); n_fail++; end
    n_checks++;
  endtask

  task automatic test_ena();
    send(c_LIM, 8'd255);
    send(c_UP, 8'd1);
    cyc();
    if (count !== 8'd1) begin $display("FAIL ena_pre: got %0d expected 1", count); n_fail++; end
    n_checks++;
    ena       = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = c_STOP;
    #1;
    if (cmd_ready !== 1'b0) begin $display("FAIL ena_ready: got %b expected 0", cmd_ready); n_fail++; end
    n_checks++;
    repeat (3) cyc();
    if (count !== 8'd1 || state_o !== 2'd1 || done !== 1'b0 || cmd_err !== 1'b0) begin
      $display("FAIL ena_freeze: count=%0d state=%0d done=%b cmd_err=%b expected 1 1 0 0",
               count, state_o, done, cmd_err); n_fail++;
    end
    n_checks++;
    ena       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = c_NOP;
    cyc();
    if (count !== 8'd2 || state_o !== 2'd1) begin
      $display("FAIL ena_resume: count=%0d state=%0d expected 2 1", count, state_o); n_fail++;
    end
    n_checks++;
    send(c_STOP, 8'd0);
  endtask

  task automatic test_wrap_down();
    send(c_LOAD, 8'd0);
    send(c_LIM, 8'd250);
    send(c_DOWN, 8'd0);
    cyc();
    if (count !== 8'd255) begin $display("FAIL wrap_0_255: got %0d expected 255", count); n_fail++; end
    n_checks++;
    cyc();
    if (count !== 8'd254) begin $display("FAIL wrap_254: got %0d expected 254", count); n_fail++; end
    n_checks++;
    send(c_STOP, 8'd0);
  endtask

  task automatic test_reset_midrun();
    send(c_LOAD, 8'h78);
    send(c_LIM, 8'hFF);
    send(c_UP, 8'd0);
    cyc();
    cyc();
    if (count !== 8'h7A) begin $display("FAIL rm_pre: got %0h expected 7a", count); n_fail++; end
    n_checks++;
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = c_LOAD;
    cmd_data  = 8'h55;
    cyc();
    if (count !== 8'd0 || state_o !== 2'd0 || running !== 1'b0 || done !== 1'b0) begin
      $display("FAIL rm_reset: count=%0d state=%0d running=%b done=%b expected 0 0 0 0",
               count, state_o, running, done); n_fail++;
    end
    n_checks++;
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = c_NOP;
    cmd_data  = '0;
    // Limit restored to all ones and prescale to 0: one step per cycle,
    // terminal at 0xFF rather than wrapping.
    send(c_LOAD, 8'hFD);
    send(c_UP, 8'd0);
    cyc();
    cyc();
    if (count !== 8'hFF || done !== 1'b0) begin
      $display("FAIL rm_ff: count=%0h done=%b expected ff 0", count, done); n_fail++;
    end
    n_checks++;
    cyc();
    if (count !== 8'hFF || done !== 1'b1 || state_o !== 2'd3) begin
      $display("FAIL rm_limit_ff: count=%0h done=%b state=%0d expected ff 1 3", count, done, state_o); n_fail++;
    end
    n_checks++;
  endtask

  initial begin
    rst_n     = 1'b0;
    ena       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = c_NOP;
    cmd_data  = '0;
    test_reset();
    test_oneshot_up();
    test_prescale();
    test_autoreload_down();
    test_illegal();
    test_pause_on_tick();
    test_stop_on_tick();
    test_ena();
    test_wrap_down();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
